// File: rtl/reset_sequencer.sv
// Startup / reset sequencer for the clk50 domain: holds NUM_STAGES resets asserted,
// then releases them in ascending order, each gated by its own lock and a gap counter.
module reset_sequencer #(
    parameter int NUM_STAGES      = 3,
    parameter int STARTUP_CYCLES  = 256,
    parameter int MIN_RST_CYCLES  = 16,
    parameter int STAGE_GAP       = 16,
    parameter int LOCK_LOSS_RESET = 1,
    parameter int CNT_W           = 16
) (
    input  logic                  clk50,
    input  logic                  rst_n,
    input  logic                  rst_from_master,
    input  logic [NUM_STAGES-1:0] lock,
    output logic [NUM_STAGES-1:0] reset_out,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [7:0]            rst_events
);

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_WAIT_REQ = 2'd1,
        ST_RELEASE  = 2'd2,
        ST_RUN      = 2'd3
    } seq_state_e;

    localparam int STG_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    localparam logic [CNT_W-1:0]      STARTUP_TGT  = CNT_W'(STARTUP_CYCLES);
    localparam logic [CNT_W-1:0]      MIN_RST_TGT  = CNT_W'(MIN_RST_CYCLES);
    localparam logic [CNT_W-1:0]      GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0]      LAST_STAGE   = STG_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ASSERTED = {NUM_STAGES{1'b1}};

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

    (* ASYNC_REG = "TRUE" *) logic                  req_meta_r;
    (* ASYNC_REG = "TRUE" *) logic                  req_sync_r;
    (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] lock_meta_r;
    (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] lock_sync_r;

    seq_state_e            state_r, state_nx_s;
    logic [CNT_W-1:0]      cnt_r, cnt_nx_s;
    logic [CNT_W-1:0]      tgt_r, tgt_nx_s;
    logic [STG_W-1:0]      stage_r, stage_nx_s;
    logic [NUM_STAGES-1:0] reset_out_r, reset_nx_s;
    logic                  ready_r, ready_nx_s;
    logic [7:0]            events_r, events_nx_s;

    logic                  req_s;
    logic [NUM_STAGES-1:0] lock_s;
    logic [NUM_STAGES-1:0] stage_oh_s;
    logic                  cur_lock_s;
    logic                  lock_lost_s;

    // Two-flop synchronisers for the asynchronous request and lock inputs.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            req_meta_r  <= 1'b0;
            req_sync_r  <= 1'b0;
            lock_meta_r <= {NUM_STAGES{1'b0}};
            lock_sync_r <= {NUM_STAGES{1'b0}};
        end else begin
            req_meta_r  <= rst_from_master;
            req_sync_r  <= req_meta_r;
            lock_meta_r <= lock;
            lock_sync_r <= lock_meta_r;
        end
    end

    assign req_s      = req_sync_r;
    assign lock_s     = lock_sync_r;
    assign stage_oh_s = NUM_STAGES'(1'b1) << stage_r;
    assign cur_lock_s = |(lock_s & stage_oh_s);

    // A released stage is one whose reset is already low; only those can report a loss.
    assign lock_lost_s = (LOCK_LOSS_RESET != 0) ? (|(~reset_out_r & ~lock_s)) : 1'b0;

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_nx_s  = state_r;
        cnt_nx_s    = cnt_r;
        tgt_nx_s    = tgt_r;
        stage_nx_s  = stage_r;
        reset_nx_s  = reset_out_r;
        ready_nx_s  = ready_r;
        events_nx_s = events_r;

        case (state_r)
            ST_HOLD: begin
                if (req_s) begin
                    state_nx_s = ST_WAIT_REQ;
                    cnt_nx_s   = {CNT_W{1'b0}};
                end else if (cnt_r == (tgt_r - CNT_W'(1))) begin
                    state_nx_s = ST_RELEASE;
                    cnt_nx_s   = {CNT_W{1'b0}};
                    stage_nx_s = {STG_W{1'b0}};
                end else begin
                    cnt_nx_s   = cnt_r + CNT_W'(1);
                end
            end

            ST_WAIT_REQ: begin
                cnt_nx_s = {CNT_W{1'b0}};
                if (!req_s) begin
                    state_nx_s = ST_HOLD;
                    tgt_nx_s   = MIN_RST_TGT;
                end else begin
                    state_nx_s = ST_WAIT_REQ;
                end
            end

            ST_RELEASE: begin
                // A request outranks a simultaneous lock loss and is counted once.
                if (req_s) begin
                    state_nx_s  = ST_WAIT_REQ;
                    cnt_nx_s    = {CNT_W{1'b0}};
                    stage_nx_s  = {STG_W{1'b0}};
                    reset_nx_s  = ALL_ASSERTED;
                    ready_nx_s  = 1'b0;
                    events_nx_s = sat_inc8(events_r);
                end else if (lock_lost_s) begin
                    state_nx_s  = ST_HOLD;
                    tgt_nx_s    = MIN_RST_TGT;
                    cnt_nx_s    = {CNT_W{1'b0}};
                    stage_nx_s  = {STG_W{1'b0}};
                    reset_nx_s  = ALL_ASSERTED;
                    ready_nx_s  = 1'b0;
                    events_nx_s = sat_inc8(events_r);
                end else if (!cur_lock_s) begin
                    cnt_nx_s    = {CNT_W{1'b0}};
                end else if (cnt_r == GAP_LAST) begin
                    cnt_nx_s    = {CNT_W{1'b0}};
                    reset_nx_s  = reset_out_r & ~stage_oh_s;
                    if (stage_r == LAST_STAGE) begin
                        state_nx_s = ST_RUN;
                        ready_nx_s = 1'b1;
                    end else begin
                        stage_nx_s = stage_r + STG_W'(1);
                    end
                end else begin
                    cnt_nx_s    = cnt_r + CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (req_s) begin
                    state_nx_s  = ST_WAIT_REQ;
                    cnt_nx_s    = {CNT_W{1'b0}};
                    stage_nx_s  = {STG_W{1'b0}};
                    reset_nx_s  = ALL_ASSERTED;
                    ready_nx_s  = 1'b0;
                    events_nx_s = sat_inc8(events_r);
                end else if (lock_lost_s) begin
                    state_nx_s  = ST_HOLD;
                    tgt_nx_s    = MIN_RST_TGT;
                    cnt_nx_s    = {CNT_W{1'b0}};
                    stage_nx_s  = {STG_W{1'b0}};
                    reset_nx_s  = ALL_ASSERTED;
                    ready_nx_s  = 1'b0;
                    events_nx_s = sat_inc8(events_r);
                end else begin
                    state_nx_s  = ST_RUN;
                end
            end

            default: begin
                state_nx_s = ST_HOLD;
                tgt_nx_s   = MIN_RST_TGT;
                cnt_nx_s   = {CNT_W{1'b0}};
                stage_nx_s = {STG_W{1'b0}};
                reset_nx_s = ALL_ASSERTED;
                ready_nx_s = 1'b0;
            end
        endcase
    end

    // State, counters and all outputs; a state change and its outputs land on the same edge.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_HOLD;
            cnt_r       <= {CNT_W{1'b0}};
            tgt_r       <= STARTUP_TGT;
            stage_r     <= {STG_W{1'b0}};
            reset_out_r <= ALL_ASSERTED;
            ready_r     <= 1'b0;
            events_r    <= 8'd0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            tgt_r       <= tgt_nx_s;
            stage_r     <= stage_nx_s;
            reset_out_r <= reset_nx_s;
            ready_r     <= ready_nx_s;
            events_r    <= events_nx_s;
        end
    end

    assign reset_out  = reset_out_r;
    assign ready      = ready_r;
    assign state      = state_r;
    assign rst_events = events_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: expected output changes are queued with their
// edge number; monitors pop and compare whenever a DUT output tuple changes.
module tb_reset_sequencer;

    logic       clk50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_from_master = 1'b0;
    logic [2:0] lock = 3'b111;

    logic [2:0] ro_a, ro_b;
    logic       rdy_a, rdy_b;
    logic [1:0] st_a, st_b;
    logic [7:0] ev_a, ev_b;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int         cyc;
        logic [2:0] ro;
        logic       rdy;
        logic [1:0] st;
        logic [7:0] ev;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    reset_sequencer #(.LOCK_LOSS_RESET(1)) u_dut (
        .clk50(clk50), .rst_n(rst_n), .rst_from_master(rst_from_master), .lock(lock),
        .reset_out(ro_a), .ready(rdy_a), .state(st_a), .rst_events(ev_a)
    );

    reset_sequencer #(.LOCK_LOSS_RESET(0)) u_dut_nll (
        .clk50(clk50), .rst_n(rst_n), .rst_from_master(rst_from_master), .lock(lock),
        .reset_out(ro_b), .ready(rdy_b), .state(st_b), .rst_events(ev_b)
    );

    initial forever #10 clk50 = ~clk50;

    initial forever begin
        @(posedge clk50);
        cyc = cyc + 1;
    end

    task automatic push_exp(input bit both, input int c, input logic [2:0] ro,
                            input logic rdy, input logic [1:0] st, input logic [7:0] ev);
        exp_t e;
        e.cyc = c; e.ro = ro; e.rdy = rdy; e.st = st; e.ev = ev;
        q_a.push_back(e);
        if (both) q_b.push_back(e);
    endtask

    task automatic score(input int which, input logic [2:0] ro, input logic rdy,
                         input logic [1:0] st, input logic [7:0] ev);
        exp_t e;
        bit   empty;
        n_vec = n_vec + 1;
        empty = (which == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
        if (empty) begin
            n_err = n_err + 1;
            $display("FAIL dut%0d unexpected_change cycle %0d: got ro=%b rdy=%b st=%0d ev=%0d, required no change",
                     which, cyc, ro, rdy, st, ev);
        end else begin
            if (which == 0) e = q_a.pop_front();
            else            e = q_b.pop_front();
            if (ro !== e.ro || rdy !== e.rdy || st !== e.st || ev !== e.ev || cyc != e.cyc) begin
                n_err = n_err + 1;
                $display("FAIL dut%0d output_change: got cycle %0d ro=%b rdy=%b st=%0d ev=%0d, required cycle %0d ro=%b rdy=%b st=%0d ev=%0d",
                         which, cyc, ro, rdy, st, ev, e.cyc, e.ro, e.rdy, e.st, e.ev);
            end
        end
    endtask

    // Monitor for the lock-loss-reset instance.
    initial begin
        logic [13:0] prev;
        prev = 14'd0;
        forever begin
            @(negedge clk50);
            if ({ro_a, rdy_a, st_a, ev_a} !== prev) begin
                prev = {ro_a, rdy_a, st_a, ev_a};
                score(0, ro_a, rdy_a, st_a, ev_a);
            end
        end
    end

    // Monitor for the instance that ignores lock loss on released stages.
    initial begin
        logic [13:0] prev;
        prev = 14'd0;
        forever begin
            @(negedge clk50);
            if ({ro_b, rdy_b, st_b, ev_b} !== prev) begin
                prev = {ro_b, rdy_b, st_b, ev_b};
                score(1, ro_b, rdy_b, st_b, ev_b);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk50);
            #1;
        end
    endtask

    task automatic check_empty(input string name);
        n_vec = n_vec + 1;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL %s pending: got %0d/%0d expected changes never seen, required 0/0",
                     name, q_a.size(), q_b.size());
        end
    endtask

    // Asynchronous reset, then release right after an edge; c0 is that edge ("edge 0").
    task automatic powerup(input logic [2:0] lk, output int c0);
        @(posedge clk50);
        #2;
        rst_n = 1'b0;
        push_exp(1'b1, cyc, 3'b111, 1'b0, 2'd0, 8'd0);
        lock = lk;
        repeat (3) @(posedge clk50);
        #1;
        rst_n = 1'b1;
        c0 = cyc;
    endtask

    initial begin
        int c0, e, f, l, elast;
        logic [7:0] evx;

        // Power-up with all locks present.
        powerup(3'b111, c0);
        push_exp(1'b1, c0 + 256, 3'b111, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 272, 3'b110, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 288, 3'b100, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 304, 3'b000, 1'b1, 2'd3, 8'd0);
        wait_cyc(c0 + 310);
        check_empty("powerup");

        // 40-cycle master request from RUN.
        e = cyc;
        rst_from_master = 1'b1;
        push_exp(1'b1, e + 3, 3'b111, 1'b0, 2'd1, 8'd1);
        wait_cyc(e + 40);
        rst_from_master = 1'b0;
        f = cyc;
        push_exp(1'b1, f + 3,  3'b111, 1'b0, 2'd0, 8'd1);
        push_exp(1'b1, f + 19, 3'b111, 1'b0, 2'd2, 8'd1);
        push_exp(1'b1, f + 35, 3'b110, 1'b0, 2'd2, 8'd1);
        push_exp(1'b1, f + 51, 3'b100, 1'b0, 2'd2, 8'd1);
        push_exp(1'b1, f + 67, 3'b000, 1'b1, 2'd3, 8'd1);
        wait_cyc(f + 75);
        check_empty("master_request");

        // One-cycle loss of lock[0] in RUN: only the lock-loss-reset instance re-sequences.
        l = cyc;
        lock = 3'b110;
        push_exp(1'b0, l + 3,  3'b111, 1'b0, 2'd0, 8'd2);
        push_exp(1'b0, l + 19, 3'b111, 1'b0, 2'd2, 8'd2);
        push_exp(1'b0, l + 35, 3'b110, 1'b0, 2'd2, 8'd2);
        push_exp(1'b0, l + 51, 3'b100, 1'b0, 2'd2, 8'd2);
        push_exp(1'b0, l + 67, 3'b000, 1'b1, 2'd3, 8'd2);
        wait_cyc(l + 1);
        lock = 3'b111;
        wait_cyc(l + 75);
        check_empty("lock_loss");

        // Power-up with lock[1] late: stage 1 waits for it.
        powerup(3'b101, c0);
        push_exp(1'b1, c0 + 256, 3'b111, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 272, 3'b110, 1'b0, 2'd2, 8'd0);
        wait_cyc(c0 + 400);
        lock = 3'b111;
        push_exp(1'b1, c0 + 418, 3'b100, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 434, 3'b000, 1'b1, 2'd3, 8'd0);
        wait_cyc(c0 + 440);
        check_empty("late_lock");

        // lock[2] glitch while its gap counter is at 10 restarts the gap.
        powerup(3'b111, c0);
        push_exp(1'b1, c0 + 256, 3'b111, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 272, 3'b110, 1'b0, 2'd2, 8'd0);
        push_exp(1'b1, c0 + 288, 3'b100, 1'b0, 2'd2, 8'd0);
        wait_cyc(c0 + 296);
        lock = 3'b011;
        wait_cyc(c0 + 299);
        lock = 3'b111;
        push_exp(1'b1, c0 + 317, 3'b000, 1'b1, 2'd3, 8'd0);
        wait_cyc(c0 + 325);
        check_empty("gap_restart");

        // 300 request events in RELEASE: counter saturates, then async reset mid-RELEASE.
        powerup(3'b111, c0);
        push_exp(1'b1, c0 + 256, 3'b111, 1'b0, 2'd2, 8'd0);
        for (int i = 1; i <= 300; i++) begin
            e = c0 + 256 + 20 * (i - 1);
            evx = (i > 255) ? 8'd255 : 8'(i);
            wait_cyc(e);
            rst_from_master = 1'b1;
            push_exp(1'b1, e + 3,  3'b111, 1'b0, 2'd1, evx);
            push_exp(1'b1, e + 4,  3'b111, 1'b0, 2'd0, evx);
            push_exp(1'b1, e + 20, 3'b111, 1'b0, 2'd2, evx);
            wait_cyc(e + 1);
            rst_from_master = 1'b0;
        end
        elast = c0 + 256 + 20 * 299;
        push_exp(1'b1, elast + 36, 3'b110, 1'b0, 2'd2, 8'd255);
        wait_cyc(elast + 38);
        #1;
        rst_n = 1'b0;
        push_exp(1'b1, cyc, 3'b111, 1'b0, 2'd0, 8'd0);
        wait_cyc(elast + 44);
        check_empty("saturate_and_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised startup and reset sequencer for the clk50 domain. It holds NUM_STAGES active-high reset outputs asserted after configuration, after a master reset request, or after a loss of lock. It then releases them one at a time in ascending stage order. Each stage is gated by its own lock input and a programmable gap. Outputs are clk50-synchronous; crossing into clk125 or adc_clk happens in the existing 2-stage synchronizers downstream.

Parameters:
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
STARTUP_CYCLES, 256, clk50 cycles all outputs stay asserted after rst_n deasserts (>=1)
MIN_RST_CYCLES, 16, minimum hold after a request or lock-loss event, counted once the request has gone low (>=1)
STAGE_GAP, 16, consecutive cycles lock[k] must be high before reset_out[k] releases (>=1)
LOCK_LOSS_RESET, 1, when 1, loss of lock on an already-released stage triggers a full re-sequence
CNT_W, 16, internal counter width; must hold max(STARTUP_CYCLES, MIN_RST_CYCLES, STAGE_GAP)

Ports:
clk50  input  1  buffered 50 MHz clock
rst_n  input  1  asynchronous active-low reset; deassertion synchronised externally
rst_from_master  input  1  asynchronous active-high reset request from the master FPGA
lock  input  NUM_STAGES  asynchronous per-stage prerequisite (PLL/MMCM lock etc.)
reset_out  output  NUM_STAGES  active-high resets; bit 0 releases first
ready  output  1  high when all stages are released
state  output  2  encoded FSM state: 0 HOLD, 1 WAIT_REQ, 2 RELEASE, 3 RUN
rst_events  output  8  saturating count of re-sequence events since rst_n

Behaviour:
- rst_n low: FSM=HOLD, hold target=STARTUP_CYCLES, counter=0, stage index=0, reset_out=all 1, ready=0, rst_events=0, all sync flops 0.
- rst_from_master and each lock bit pass through a 2-flop ASYNC_REG synchroniser (req_s, lock_s). Nothing uses the raw inputs.
- All outputs are registered. A state change is visible on the outputs on the same edge that enters the new state.
- HOLD:
  - counter increments each cycle.
  - When counter = target-1, go to RELEASE with stage=0 and counter cleared.
  - If req_s is high, go to WAIT_REQ.
- WAIT_REQ:
  - counter held at 0 while req_s is high.
  - When req_s is low, go to HOLD with target=MIN_RST_CYCLES.
- RELEASE (stage k):
  - counter increments while lock_s[k]=1 and clears to 0 whenever lock_s[k]=0.
  - When counter = STAGE_GAP-1 with lock_s[k]=1, reset_out[k]<=0 and counter is cleared.
  - If k=NUM_STAGES-1, go to RUN with ready<=1. Otherwise stage<=k+1.
- RUN: outputs are static.
- Request event: req_s=1 in RELEASE or RUN.
  - Same edge: state<=WAIT_REQ, reset_out<=all 1, ready<=0, stage<=0, rst_events+1 (saturates at 255).
  - Latency: reset_out is asserted 3 clk50 edges after rst_from_master rises.
- Lock-loss event (LOCK_LOSS_RESET=1): lock_s[j]=0 for any already-released stage j, in RELEASE or RUN.
  - Same edge: state<=HOLD, target=MIN_RST_CYCLES, counter=0, reset_out<=all 1, ready<=0, stage<=0, rst_events+1.
  - With LOCK_LOSS_RESET=0, lock is examined only for the stage currently being released.
- Simultaneous request and lock-loss: request wins (WAIT_REQ); counts as one event.
- A request during HOLD goes to WAIT_REQ and is not counted. A request during WAIT_REQ keeps holding. Neither affects rst_events.
- Reset outputs never deassert out of order: reset_out[k]=0 implies reset_out[0..k-1]=0.
- No output glitches: each reset_out bit changes at most once per clock edge and only in the directions listed above.
- rst_n assertion at any time returns all registers to their reset values immediately.

Test Plan:
1. Power-up with default params, lock=3'b111 and rst_from_master=0 throughout. Release rst_n at edge 0 -> reset_out[0] falls at edge 272, reset_out[1] at 288, reset_out[2] at 304, ready=1 at 304, rst_events=0, state=3.
2. From RUN, pulse rst_from_master high for 40 cycles starting at edge E -> reset_out=3'b111 and ready=0 at E+3. HOLD is entered 3 edges after the request falls, and stages release MIN_RST_CYCLES+16 / +32 / +48 cycles after entering HOLD. rst_events=1.
3. Power-up with lock[1] low until edge 400 -> reset_out[0] falls at 272. reset_out[1] falls at 400+2+16 = edge 418, reset_out[2] at 434. reset_out[1] stays high until then.
4. In RUN, drop lock[0] for 1 cycle with LOCK_LOSS_RESET=1 -> all outputs reassert 3 edges later and the full re-sequence runs, rst_events=1. Repeat with LOCK_LOSS_RESET=0 -> no change to the outputs.
5. Toggle lock[2] low mid-gap (counter=10) during release of stage 2 -> the gap restarts, release happens 16 cycles after lock_s[2] returns high, and rst_events is unchanged.
6. Trigger 300 request events, then assert rst_n mid-RELEASE -> rst_events saturates at 255. On rst_n, outputs return to 3'b111 and rst_events to 0 asynchronously.
